// File: rtl/ws2812_multilane_shifter.sv
// ws2812_multilane_shifter: lock-step WS2812/SK6812 serialiser for NUM_CH LED lanes sharing one bit timer.
// Latency: first rising edge on out one cycle after the pixel transfer; each frame ends with a RESET_NS low guard.
// Backpressure: in_ready only in LOAD (plus BIT while the holding register is empty when WS2812_PREFETCH_EN is defined).
//
// Ports:
//   clk, rst      clock, synchronous active-high reset (restarts the full latch guard)
//   start         begin a frame; only looked at in IDLE
//   in_data       lane i = in_data[i*PIXEL_BITS +: PIXEL_BITS], captured on in_valid & in_ready
//   in_valid      in_data valid
//   in_ready      transfer accepted this cycle
//   out           registered serial output per lane, MSB first
//   busy          high in every state except IDLE
//   frame_done    one-cycle pulse on each GUARD->IDLE transition
//
// Optional build macro: WS2812_PREFETCH_EN adds a one-pixel holding register so consecutive pixels are
// emitted without the one-cycle LOAD gap. Without it the last bit of each pixel is one cycle longer.

module ws2812_multilane_shifter #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int NUM_CH     = 4,
  parameter int PIXEL_BITS = 24,
  parameter int T0H_NS     = 350,
  parameter int T1H_NS     = 800,
  parameter int BIT_NS     = 1250,
  parameter int RESET_NS   = 60000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_CH*PIXEL_BITS-1:0]   in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [NUM_CH-1:0]              out,
  output logic                           busy,
  output logic                           frame_done
);

  // floor(CLK_HZ * ns / 1e9), clamped to at least one cycle; 64-bit so long guards do not overflow.
  function automatic int to_cycles(input int ns);
    longint c;
    c = (longint'(CLK_HZ) * longint'(ns)) / longint'(1000000000);
    return (c < 1) ? 1 : int'(c);
  endfunction

  localparam int T0HC = to_cycles(T0H_NS);
  localparam int T1HC = to_cycles(T1H_NS);
  localparam int BITC = to_cycles(BIT_NS);
  localparam int RSTC = to_cycles(RESET_NS);

  localparam int GW = $clog2(RSTC + 1);
  localparam int PW = $clog2(BITC + 1);
  localparam int BW = $clog2(PIXEL_BITS + 1);
  localparam int DW = NUM_CH * PIXEL_BITS;

  localparam logic [PW-1:0] T0H_P    = PW'(T0HC);
  localparam logic [PW-1:0] T1H_P    = PW'(T1HC);
  localparam logic [PW-1:0] PH_LAST  = PW'(BITC - 1);
  localparam logic [GW-1:0] GRD_INIT = GW'(RSTC - 1);
  localparam logic [BW-1:0] BIT_INIT = BW'(PIXEL_BITS - 1);

  generate
    if (T1HC >= BITC || T0HC >= T1HC) begin : g_bad_timing
      $error("ws2812_multilane_shifter: need T0H < T1H < BIT in clock cycles");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_lanes
      $error("ws2812_multilane_shifter: NUM_CH must be 1..16");
    end
    if (CLK_HZ < 12_000_000) begin : g_bad_clk
      $error("ws2812_multilane_shifter: CLK_HZ must be >= 12 MHz");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_GUARD = 2'd0,
    S_IDLE  = 2'd1,
    S_LOAD  = 2'd2,
    S_BIT   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   guard_q, guard_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [BW-1:0]   bitcnt_q, bitcnt_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic [NUM_CH-1:0] out_q, out_d;
  logic            done_q, done_d;
  logic            pix_end;

`ifdef WS2812_PREFETCH_EN
  logic [DW-1:0]   hold_q, hold_d;
  logic            hold_vld_q, hold_vld_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_GUARD;
      guard_q  <= GRD_INIT;
      phase_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
`ifdef WS2812_PREFETCH_EN
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      guard_q  <= guard_d;
      phase_q  <= phase_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      out_q    <= out_d;
      done_q   <= done_d;
`ifdef WS2812_PREFETCH_EN
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    guard_d  = guard_q;
    phase_d  = phase_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
    in_ready = 1'b0;
    out_d    = '0;
    pix_end  = (phase_q == PH_LAST) && (bitcnt_q == '0);
`ifdef WS2812_PREFETCH_EN
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
`endif

    case (state_q)
      S_GUARD: begin
        if (guard_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          guard_d = guard_q - GW'(1);
        end
      end

      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end

      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift_d  = in_data;
          bitcnt_d = BIT_INIT;
          phase_d  = '0;
          state_d  = S_BIT;
        end else begin
          // No pixel waiting: the frame is over.
          guard_d = GRD_INIT;
          state_d = S_GUARD;
        end
      end

      S_BIT: begin
`ifdef WS2812_PREFETCH_EN
        in_ready = !hold_vld_q;
`endif
        if (phase_q != PH_LAST) begin
          phase_d = phase_q + PW'(1);
        end else if (bitcnt_q != '0) begin
          for (int i = 0; i < NUM_CH; i++) begin
            shift_d[i*PIXEL_BITS +: PIXEL_BITS] = {shift_q[i*PIXEL_BITS +: PIXEL_BITS-1], 1'b0};
          end
          bitcnt_d = bitcnt_q - BW'(1);
          phase_d  = '0;
        end else begin
`ifdef WS2812_PREFETCH_EN
          // Reload straight from the holding register, or from the bus when the
          // transfer lands on this very cycle, so the next pixel starts without a gap.
          if (hold_vld_q) begin
            shift_d    = hold_q;
            hold_vld_d = 1'b0;
            bitcnt_d   = BIT_INIT;
            phase_d    = '0;
          end else if (in_valid) begin
            shift_d  = in_data;
            bitcnt_d = BIT_INIT;
            phase_d  = '0;
          end else begin
            guard_d = GRD_INIT;
            state_d = S_GUARD;
          end
`else
          state_d = S_LOAD;
`endif
        end
`ifdef WS2812_PREFETCH_EN
        if (in_ready && in_valid && !pix_end) begin
          hold_d     = in_data;
          hold_vld_d = 1'b1;
        end
`endif
      end

      default: begin
        state_d = S_GUARD;
        guard_d = GRD_INIT;
      end
    endcase

    // Output is computed from next-state values so the flop shows the bit aligned with
    // the phase counter; every lane is high at phase 0, so all lanes rise together.
    for (int i = 0; i < NUM_CH; i++) begin
      out_d[i] = (state_d == S_BIT) &&
                 (phase_d < (shift_d[i*PIXEL_BITS + PIXEL_BITS - 1] ? T1H_P : T0H_P));
    end
  end

  assign out        = out_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_q;

endmodule

// File: tb/tb_ws2812_multilane_shifter.sv
module tb_ws2812_multilane_shifter;

  localparam int NUM_CH = 4;
  localparam int PB     = 24;
  localparam int T0C    = 4;
  localparam int T1C    = 9;
  localparam int BITC   = 15;
  localparam int RSTC   = 720;
`ifdef WS2812_PREFETCH_EN
  localparam bit PREFETCH = 1'b1;
`else
  localparam bit PREFETCH = 1'b0;
`endif
  // Rising edge to rising edge across a pixel boundary inside a frame.
  localparam int LAST_GAP = PREFETCH ? BITC : BITC + 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic                   in_valid = 1'b0;
  logic [NUM_CH*PB-1:0]   in_data = '0;
  logic                   in_ready;
  logic [NUM_CH-1:0]      out;
  logic                   busy;
  logic                   frame_done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [NUM_CH-1:0] val;     // bit value per lane
    int                period;  // cycles to the next rising edge, 0 = last bit of frame
  } bit_exp_t;

  bit_exp_t q_bits[$];
  int       q_busy[$];
  int       mon_hi[NUM_CH];

  always #5 clk = ~clk;

  ws2812_multilane_shifter dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out        (out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [NUM_CH*PB-1:0] rand_px();
    logic [NUM_CH*PB-1:0] p;
    for (int i = 0; i < NUM_CH; i++) p[i*PB +: PB] = PB'($urandom);
    return p;
  endfunction

  // Reference: a pixel is PB bits per lane, MSB first; each bit is one period of
  // BITC cycles, high for T1C (one) or T0C (zero) cycles.
  task automatic push_pixel(input logic [NUM_CH*PB-1:0] px, input bit last_in_frame);
    bit_exp_t e;
    for (int b = PB - 1; b >= 0; b--) begin
      for (int i = 0; i < NUM_CH; i++) e.val[i] = px[i*PB + b];
      if (b != 0)             e.period = BITC;
      else if (last_in_frame) e.period = 0;
      else                    e.period = LAST_GAP;
      q_bits.push_back(e);
    end
  endtask

  task automatic finish_bit(input int period);
    bit_exp_t e;
    if (q_bits.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_bit: serial bit seen (period %0d) with none expected", period);
    end else begin
      e = q_bits.pop_front();
      check("bit_period", period, e.period);
      for (int i = 0; i < NUM_CH; i++)
        check($sformatf("lane%0d_high_cycles", i), mon_hi[i], e.val[i] ? T1C : T0C);
    end
  endtask

  // Monitor: decodes serial bits from the pins and checks frame length at frame_done.
  initial begin : monitor
    logic [NUM_CH-1:0] prev;
    bit in_bit;
    int cyc, busy_cnt, rdy_idle;
    prev = '0; in_bit = 0; cyc = 0; busy_cnt = 0; rdy_idle = 0;
    foreach (mon_hi[i]) mon_hi[i] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q_bits.delete();
        q_busy.delete();
        in_bit = 0; busy_cnt = 0; rdy_idle = 0;
        prev = out;
      end else begin
        if (out != '0 && prev == '0) begin
          check("lanes_rise_together", out, {NUM_CH{1'b1}});
          if (in_bit) finish_bit(cyc);
          in_bit = 1; cyc = 0;
          foreach (mon_hi[i]) mon_hi[i] = 0;
        end
        if (in_bit) begin
          cyc++;
          for (int i = 0; i < NUM_CH; i++) mon_hi[i] += int'(out[i]);
          if (out == '0 && cyc >= BITC + 5) begin
            finish_bit(0);
            in_bit = 0;
          end
        end
        if (busy) busy_cnt++;
        if (in_ready && !busy) rdy_idle++;
        if (frame_done) begin
          if (q_busy.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame_done: pulse after %0d busy cycles, none expected", busy_cnt);
          end else begin
            check("frame_busy_cycles", busy_cnt, q_busy.pop_front());
          end
          check("in_ready_while_idle", rdy_idle, 0);
          busy_cnt = 0; rdy_idle = 0;
        end
        prev = out;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      failures++;
      $display("FAIL wait_idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
    @(posedge clk); #1;
  endtask

  // Returns 1 when in_ready was seen (transfer on the next edge).
  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 2000);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_ready_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
  endtask

  task automatic run_frame(input int npix, input logic [NUM_CH*PB-1:0] first_px);
    logic [NUM_CH*PB-1:0] px;
    bit ok;
    if (npix == 0)     q_busy.push_back(1 + RSTC);
    else if (PREFETCH) q_busy.push_back(1 + npix*PB*BITC + RSTC);
    else               q_busy.push_back((npix + 1) + npix*PB*BITC + RSTC);
    px       = first_px;
    in_data  = px;
    in_valid = (npix > 0);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int p = 0; p < npix; p++) begin
      wait_ready(ok);
      if (!ok) break;
      push_pixel(px, p == npix - 1);
      @(posedge clk); #1;
      if (p == npix - 1) begin
        in_valid = 1'b0;
        in_data  = rand_px();
      end else begin
        px      = rand_px();
        in_data = px;
      end
      if (p == 0) begin
        // start while shifting must be ignored
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    in_valid = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    // start during the guard (or tail of the last pixel) must be ignored too
    start   = 1'b1;
    in_data = rand_px();
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
  endtask

  task automatic reset_mid_frame();
    logic [NUM_CH*PB-1:0] px;
    bit ok;
    px       = rand_px();
    in_data  = px;
    in_valid = 1'b1;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_ready(ok);
    push_pixel(px, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Now at bit 0 phase 0; move to bit 10 phase 2 where every lane is high.
    repeat (10*BITC + 2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("out_high_before_rst", out, {NUM_CH{1'b1}});
    @(posedge clk); #1;
    rst = 1'b0;
    q_busy.push_back(RSTC);
    @(negedge clk);
    check("rst_mid_out", out, 0);
    check("rst_mid_in_ready", in_ready, 0);
    check("rst_mid_busy", busy, 1);
    wait_idle();
  endtask

  initial begin : driver
    logic [NUM_CH*PB-1:0] fixed_px;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q_busy.push_back(RSTC);
    @(negedge clk);
    check("reset_out", out, 0);
    check("reset_busy", busy, 1);
    check("reset_in_ready", in_ready, 0);
    check("reset_frame_done", frame_done, 0);
    wait_idle();
    check("idle_busy", busy, 0);

    fixed_px = {24'h000000, 24'h800001, 24'h00FF00, 24'hFF0000};
    run_frame(1, fixed_px);
    run_frame(3, rand_px());
    run_frame(0, rand_px());
    reset_mid_frame();
    for (int f = 0; f < 6; f++) run_frame(int'($urandom_range(0, 3)), rand_px());

    repeat (5) @(posedge clk);
    check("bits_left_over", q_bits.size(), 0);
    check("frames_left_over", q_busy.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
